// File: rtl/mix_columns_seq_pkg.sv
// Shared types, GF(2^8) constants and helpers for the sequential AES MixColumns block.
package mix_columns_seq_pkg;

    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned COL_W     = 32;
    localparam int unsigned STATE_W   = NUM_COLS * COL_W;
    localparam int unsigned COL_IDX_W = $clog2(NUM_COLS);

    localparam logic [7:0] GF_POLY = 8'h1B;
    localparam logic [7:0] GF_02   = 8'h02;
    localparam logic [7:0] GF_03   = 8'h03;
    localparam logic [7:0] GF_09   = 8'h09;
    localparam logic [7:0] GF_0B   = 8'h0B;
    localparam logic [7:0] GF_0D   = 8'h0D;
    localparam logic [7:0] GF_0E   = 8'h0E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MIX,
        ST_DONE
    } mc_state_e;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply; collapses to a few XORs for a constant b.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Accept/deliver handshake bundle between a producer/consumer and mix_columns_seq.
interface mix_columns_seq_if;
    import mix_columns_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               inv;
    logic [STATE_W-1:0] state_in;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] state_out;
    logic               busy;

    modport master (
        output in_valid, inv, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, inv, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );

endinterface

// File: rtl/mix_columns_seq_mix_col_word.sv
// Combinational single-column (Inv)MixColumns: circulant matrix over GF(2^8).
module mix_col_word
    import mix_columns_seq_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    input  logic             i_inv,
    output logic [COL_W-1:0] o_col_c
);

    logic [0:3][7:0] w_a;
    logic [0:3][7:0] w_coef;
    logic [0:3][7:0] w_b;

    assign w_a = i_col;

    // Row i output uses coefficient (j - i) mod 4 for input byte j.
    always_comb begin
        w_coef = i_inv ? {GF_0E, GF_0B, GF_0D, GF_09} : {GF_02, GF_03, 8'h01, 8'h01};
        w_b    = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_b[i] = w_b[i] ^ gf_mul(w_a[j], w_coef[2'(j - i)]);
            end
        end
    end

    assign o_col_c = w_b;

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES (Inv)MixColumns: one shared column unit, one column per cycle.
module mix_columns_seq
    import mix_columns_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mix_columns_seq_if.slave   bus
);

    mc_state_e                         r_state;
    logic [0:NUM_COLS-1][COL_W-1:0]    r_src;
    logic [0:NUM_COLS-1][COL_W-1:0]    r_res;
    logic                              r_inv;
    logic [COL_IDX_W-1:0]              r_col_idx;
    logic                              r_in_ready;
    logic                              r_out_valid;
    logic                              r_busy;
    logic [COL_W-1:0]                  w_col_out;

    mix_col_word u_col (
        .i_col   (r_src[r_col_idx]),
        .i_inv   (r_inv),
        .o_col_c (w_col_out)
    );

    // Control FSM with registered handshake flags; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_src       <= '0;
            r_res       <= '0;
            r_inv       <= 1'b0;
            r_col_idx   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_src      <= bus.state_in;
                        r_inv      <= bus.inv;
                        r_col_idx  <= '0;
                        r_state    <= ST_MIX;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_MIX: begin
                    r_res[r_col_idx] <= w_col_out;
                    r_col_idx        <= r_col_idx + COL_IDX_W'(1);
                    if (r_col_idx == COL_IDX_W'(NUM_COLS - 1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.state_out = r_res;

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 Parameter: none; the column count is fixed at 4 and the word width at 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  a 128-bit state is offered.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 inv  input  1  sampled at accept; 0 = MixColumns, 1 = InvMixColumns.
REQ-007 state_in  input  128  AES state; column c = state_in[127-32c -: 32]; row0 is the MSB byte of each column.
REQ-008 out_valid  output  1  result is held on state_out.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 state_out  output  128  mixed state, same column/row packing as state_in.
REQ-011 busy  output  1  high in MIX and DONE.

Function
REQ-012 FSM states are IDLE, MIX and DONE; encoding is free.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready, latch state_in and inv, clear col_idx to 0, go to MIX.
REQ-014 MIX: in_ready=0; each cycle feed column col_idx of the latched state through one shared column unit and write its 32-bit result into result column col_idx; col_idx increments mod 4.
REQ-015 MIX: after the write of column 3, go to DONE; MIX lasts exactly 4 cycles.
REQ-016 Latency: out_valid rises exactly 4 clock edges after the accept edge.
REQ-017 DONE: out_valid=1; state_out and all outputs are stable until out_valid&&out_ready.
REQ-018 DONE: on out_ready, go to IDLE; out_valid=0 and in_ready=1 on the next cycle (no same-cycle reaccept).
REQ-019 Throughput: at most one state per 6 cycles when out_ready is held high.
REQ-020 Column unit forward: b0'=2a0^3a1^a2^a3 (rotated per row) over GF(2^8), reduction polynomial 0x11B.
REQ-021 Column unit inverse: coefficients {0E,0B,0D,09} with the same rotation.
REQ-022 in_valid, inv and state_in are ignored outside IDLE; changing them during MIX or DONE does not affect the result.
REQ-023 out_ready is ignored outside DONE.
REQ-024 state_out is undefined-free: it reads the result register at all times, and that register is 0 until the first write.

Reset
REQ-025 With rst=1 at an edge: FSM=IDLE, col_idx=0, latched state, inv and result=0; outputs in_ready=1, out_valid=0, busy=0, state_out=0.
REQ-026 Reset during MIX or DONE aborts the operation; no partial result is ever presented with out_valid=1.
REQ-027 rst has priority over every handshake in the same cycle.

Structure
REQ-028 The shared package holds: the FSM state typedef, the GF constants 0x1B, 0x02, 0x03, 0x09, 0x0B, 0x0D and 0x0E, and the column count 4.
REQ-029 One combinational sub-module, mix_col_word (32-bit column in, inv in, 32-bit column out), is instantiated exactly once.
REQ-030 Column selection and result write use col_idx multiplexing; the design has no per-column duplicated logic.

Verification
REQ-031 Forward, single column: state_in = db135345_f20a225c_01010101_c6c6c6c6 -> state_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 4 edges after accept.
REQ-032 Inverse round-trip: inv=1, state_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> state_out = db135345_f20a225c_01010101_c6c6c6c6.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE, and toggle state_in and inv meanwhile -> state_out is unchanged, in_ready=0, and the result is delivered on the first out_ready=1.
REQ-034 Mid-op reset: assert rst in the 2nd MIX cycle -> the next cycle has in_ready=1, out_valid=0 and state_out=0; a new input d4d4d4d5_2d26314c_... then completes correctly (column 0 = d5d5d7d6, column 1 = 4d7ebdf8).
REQ-035 Back-to-back: in_valid held high with out_ready=1 -> exactly one accept per 6 cycles, and in_ready never coincides with busy.
REQ-036 Random: 1000 random states with random inv compared against a reference model -> zero mismatches.
